// File: rtl/seg7_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl_if
// Digit-write bus for the 7-segment scan controller.
//
// Signals:
//   wr_valid  master->slave  digit-write request
//   wr_ready  slave->master  write can be accepted (low while a commit is pending)
//   wr_addr   master->slave  digit index to write
//   wr_data   master->slave  BCD value to write
//   commit    master->slave  transfer shadow digits to the display at the next frame boundary
// ---------------------------------------------------------------------------
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int ADDR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        wr_data;
    logic              commit;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        output commit,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        input  commit,
        output wr_ready
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
// Multiplexed 7-segment display scanner with double-buffered digit storage.
// Digits are written into shadow registers; a commit copies all shadow digits
// into the displayed (active) registers atomically at the next frame boundary,
// so a partially updated number is never shown.
//
// Each digit gets a BLANK phase (all segments and selects off, prevents
// ghosting while the digit drivers switch) followed by a SHOW phase.
//
// Ports:
//   clk         sole clock, rising edge
//   reset       asynchronous active-high reset
//   wr_if       digit-write bus (slave side): wr_valid/wr_ready/wr_addr/wr_data/commit
//   led_out     segment bus {g,f,e,d,c,b,a}, active-high
//   digit_sel   one-hot digit enable, active-high
//   frame_done  one-cycle pulse after each completed scan frame
//   io_oeb      pad output-enable-bar, constant zero (pads always driven)
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 16000,
    parameter int BLANK_CYCLES = 160
) (
    input  logic                  clk,
    input  logic                  reset,
    seg7_scan_ctrl_if.slave       wr_if,
    output logic [6:0]            led_out,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  frame_done,
    output logic [6+NUM_DIGITS:0] io_oeb
);

    localparam int ADDR_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int IDX_W   = ADDR_W;
    localparam int MAX_CNT = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // BCD to segments {g,f,e,d,c,b,a}; non-decimal codes are dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111100;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1100111;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_frame_done;
    logic             r_pending;
    logic [3:0]       r_shadow [NUM_DIGITS];
    logic [3:0]       r_active [NUM_DIGITS];

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_boundary;
    logic             w_wr_fire;
    logic [3:0]       w_cur_digit;

    // Handshake: ready only depends on the registered pending flag.
    assign wr_if.wr_ready = ~r_pending;
    assign w_wr_fire      = wr_if.wr_valid & ~r_pending;

    assign frame_done = r_frame_done;
    assign io_oeb     = '0;

    // Scan FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_idx_nxt   = r_idx;
        w_boundary  = 1'b0;
        case (r_state)
            ST_BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_state_nxt = ST_SHOW;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SHOW: begin
                if (r_cnt == SHOW_LAST) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                    if (r_idx == IDX_LAST) begin
                        // Leaving the last digit closes the frame.
                        w_idx_nxt  = '0;
                        w_boundary = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Scan FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_BLANK;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_frame_done <= w_boundary;
        end
    end

    // Digit storage and commit handling. Writes are blocked while a commit
    // is pending, so the shadow image copied at the boundary is stable.
    // Out-of-range addresses match no digit and are dropped after handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_wr_fire && (wr_if.wr_addr == ADDR_W'(i))) begin
                    r_shadow[i] <= wr_if.wr_data;
                end
            end
            if (w_boundary && r_pending) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    r_active[i] <= r_shadow[i];
                end
                r_pending <= 1'b0;
            end else if (wr_if.commit && !r_pending) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Display outputs, decoded from registered state only
    always_comb begin
        w_cur_digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_cur_digit = r_active[i];
            end
        end
        digit_sel = '0;
        led_out   = '0;
        if (r_state == ST_SHOW) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_sel[i] = (r_idx == IDX_W'(i));
            end
            led_out = seg_decode(w_cur_digit);
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Scoreboard bench for seg7_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=4,
// BLANK_CYCLES=1, frame = 20 cycles). The stimulus process keeps a
// behavioural model (cycle count since reset, digit arrays, pending flag)
// and queues the expected display for each cycle; a monitor pops and
// compares on every falling edge.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

    localparam int ND    = 4;
    localparam int SDIV  = 4;
    localparam int BLANK = 1;
    localparam int SLOT  = SDIV + BLANK;
    localparam int FRAME = ND * SLOT;

    localparam logic [6:0] SEG [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111100, 7'b0000111,
        7'b1111111, 7'b1100111, 7'b0000000, 7'b0000000,
        7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
    };

    typedef struct packed {
        logic [ND-1:0] sel;
        logic [6:0]    led;
        logic          fd;
        logic          rdy;
    } exp_t;

    logic          clk;
    logic          reset;
    logic [6:0]    led_out;
    logic [ND-1:0] digit_sel;
    logic          frame_done;
    logic [6+ND:0] io_oeb;

    seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) u_if ();

    seg7_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SDIV),
        .BLANK_CYCLES(BLANK)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .wr_if     (u_if.slave),
        .led_out   (led_out),
        .digit_sel (digit_sel),
        .frame_done(frame_done),
        .io_oeb    (io_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];

    // Reference model
    int         m_k;
    logic       m_pend;
    logic [3:0] m_sh  [ND];
    logic [3:0] m_act [ND];

    task automatic model_reset();
        m_k    = 0;
        m_pend = 1'b0;
        for (int i = 0; i < ND; i++) begin
            m_sh[i]  = 4'd0;
            m_act[i] = 4'd0;
        end
    endtask

    // One rising edge, seen through the inputs held during the past cycle.
    task automatic model_edge();
        logic old_p;
        if (reset) return;
        old_p = m_pend;
        m_k++;
        if ((m_k % FRAME) == 0 && old_p) begin
            m_act  = m_sh;
            m_pend = 1'b0;
        end
        if (!old_p && u_if.wr_valid) m_sh[u_if.wr_addr] = u_if.wr_data;
        if (!old_p && u_if.commit) m_pend = 1'b1;
    endtask

    function automatic exp_t model_expect();
        exp_t e;
        int   pos, d, w;
        pos   = m_k % FRAME;
        d     = pos / SLOT;
        w     = pos % SLOT;
        e.sel = (w < BLANK) ? '0 : ND'(1 << d);
        e.led = (w < BLANK) ? 7'd0 : SEG[m_act[d]];
        e.fd  = (m_k > 0) && (pos == 0);
        e.rdy = ~m_pend;
        return e;
    endfunction

    task automatic tick(input logic r, input logic v, input logic [1:0] a,
                        input logic [3:0] dt, input logic c);
        @(posedge clk);
        model_edge();
        #1;
        reset         = r;
        u_if.wr_valid = v;
        u_if.wr_addr  = a;
        u_if.wr_data  = dt;
        u_if.commit   = c;
        if (r) model_reset();
        q.push_back(model_expect());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
    endtask

    task automatic idle_to_pos(input int p);
        for (int n = 0; n < 2 * FRAME && (m_k % FRAME) != p; n++) begin
            tick(1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (digit_sel !== e.sel) begin
                    n_err++;
                    $display("FAIL digit_sel k=%0d got=%b exp=%b", m_k, digit_sel, e.sel);
                end
                n_cmp++;
                if (led_out !== e.led) begin
                    n_err++;
                    $display("FAIL led_out k=%0d got=%b exp=%b", m_k, led_out, e.led);
                end
                n_cmp++;
                if (frame_done !== e.fd) begin
                    n_err++;
                    $display("FAIL frame_done k=%0d got=%b exp=%b", m_k, frame_done, e.fd);
                end
                n_cmp++;
                if (u_if.wr_ready !== e.rdy) begin
                    n_err++;
                    $display("FAIL wr_ready k=%0d got=%b exp=%b", m_k, u_if.wr_ready, e.rdy);
                end
                n_cmp++;
                if (io_oeb !== '0) begin
                    n_err++;
                    $display("FAIL io_oeb k=%0d got=%b exp=0", m_k, io_oeb);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        reset         = 1'b1;
        u_if.wr_valid = 1'b0;
        u_if.wr_addr  = '0;
        u_if.wr_data  = '0;
        u_if.commit   = 1'b0;
        model_reset();

        // Reset held, writes and commit must be ignored
        tick(1'b1, 1'b1, 2'd1, 4'd5, 1'b1);
        tick(1'b1, 1'b1, 2'd2, 4'd6, 1'b1);
        tick(1'b1, 1'b0, 2'd0, 4'd0, 1'b0);

        // Free-running scan with all digits 0
        tick(1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        idle(45);

        // Load 1,2,3,4 then commit mid-frame
        tick(1'b0, 1'b1, 2'd0, 4'd1, 1'b0);
        tick(1'b0, 1'b1, 2'd1, 4'd2, 1'b0);
        tick(1'b0, 1'b1, 2'd2, 4'd3, 1'b0);
        tick(1'b0, 1'b1, 2'd3, 4'd4, 1'b0);
        idle_to_pos(8);
        tick(1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
        idle(35);

        // Write with commit in the same cycle, then a second commit while pending
        idle_to_pos(3);
        tick(1'b0, 1'b1, 2'd2, 4'd9, 1'b1);
        tick(1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
        idle(35);

        // Non-decimal value blanks the digit
        tick(1'b0, 1'b1, 2'd1, 4'd12, 1'b1);
        idle(35);

        // Reset during digit 2 SHOW with a commit pending
        idle_to_pos(1);
        tick(1'b0, 1'b1, 2'd0, 4'd8, 1'b1);
        idle_to_pos(12);
        tick(1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
        tick(1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
        tick(1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        idle(25);

        // wr_valid held high across a pending commit
        idle_to_pos(3);
        tick(1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
        for (int i = 0; i < 25; i++) tick(1'b0, 1'b1, 2'd0, 4'd7, 1'b0);
        tick(1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
        idle(25);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0));
        end
        idle(5);

        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain left=%0d exp=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
